// File: rtl/ctrl_pkg.sv
// Shared definitions for the control-store loader: default sizes, FSM states
// and the control-word field layout.
package ctrl_pkg;

    localparam int CS_ADDR_W = 6;
    localparam int CS_DATA_W = 20;
    localparam int CS_DEPTH  = 43;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_READY = 2'd3
    } state_t;

    // Bit positions of each field inside a 20-bit control word
    localparam int F_BRANCH    = 19;
    localparam int F_IMMSEL_HI = 18;
    localparam int F_IMMSEL_LO = 16;
    localparam int F_REGWRITE  = 15;
    localparam int F_UNSIGNED  = 14;
    localparam int F_ALUSRC    = 13;
    localparam int F_ASEL      = 12;
    localparam int F_ALUOP_HI  = 11;
    localparam int F_ALUOP_LO  = 8;
    localparam int F_MEMWRITE  = 7;
    localparam int F_STSIZE_HI = 6;
    localparam int F_STSIZE_LO = 5;
    localparam int F_LDTYPE_HI = 4;
    localparam int F_LDTYPE_LO = 2;
    localparam int F_WBSEL_HI  = 1;
    localparam int F_WBSEL_LO  = 0;

    typedef struct packed {
        logic       branch;
        logic [2:0] immsel;
        logic       regwrite;
        logic       is_unsigned;
        logic       alusrc;
        logic       asel;
        logic [3:0] aluop;
        logic       memwrite;
        logic [1:0] st_size;
        logic [2:0] ld_type;
        logic [1:0] wbsel;
    } ctrl_word_t;

endpackage

// File: rtl/ctrl_store_ram.sv
// Control-store array: synchronous write, registered read. A disabled read
// returns the all-zero NOP word.
module ctrl_store_ram #(
    parameter int ADDR_W = ctrl_pkg::CS_ADDR_W,
    parameter int DATA_W = ctrl_pkg::CS_DATA_W,
    parameter int DEPTH  = ctrl_pkg::CS_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are never reset; the loader only exposes them once fully written
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/ctrl_store_loader.sv
// Loads a DEPTH-word control store through a valid/ready stream and serves
// registered lookups once a complete image is held. Option: CTRL_STORE_CHECKSUM_EN.
module ctrl_store_loader
    import ctrl_pkg::*;
#(
    parameter int ADDR_W = CS_ADDR_W,
    parameter int DATA_W = CS_DATA_W,
    parameter int DEPTH  = CS_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              ld_err,
    output logic              store_ok,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic              wr_en;
    logic              last_word;
    logic              start_ok;
    logic              rd_en;

    assign ld_ready  = (state == ST_LOAD) || (state == ST_CHECK);
    assign wr_en     = (state == ST_LOAD) && ld_valid;
    assign last_word = (idx == ADDR_W'(DEPTH - 1));
    assign start_ok  = ld_start && ((state == ST_IDLE) || (state == ST_READY));
    // Extra top bit keeps the range check correct even when DEPTH == 2**ADDR_W
    assign rd_en     = store_ok && ({1'b0, rd_addr} < (ADDR_W + 1)'(DEPTH));

`ifdef CTRL_STORE_CHECKSUM_EN
    logic [DATA_W-1:0] csum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum   <= '0;
            ld_err <= 1'b0;
        end else if (start_ok) begin
            csum   <= '0;
            ld_err <= 1'b0;
        end else if (wr_en) begin
            csum <= csum ^ ld_data;
        end else if ((state == ST_CHECK) && ld_valid && (ld_data != csum)) begin
            ld_err <= 1'b1;
        end
    end
`else
    assign ld_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            idx      <= '0;
            ld_done  <= 1'b0;
            store_ok <= 1'b0;
        end else begin
            ld_done <= 1'b0;
            case (state)
                ST_IDLE, ST_READY: begin
                    if (ld_start) begin
                        state    <= ST_LOAD;
                        idx      <= '0;
                        store_ok <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (ld_valid) begin
                        if (last_word) begin
`ifdef CTRL_STORE_CHECKSUM_EN
                            state <= ST_CHECK;
`else
                            state    <= ST_READY;
                            ld_done  <= 1'b1;
                            store_ok <= 1'b1;
`endif
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
`ifdef CTRL_STORE_CHECKSUM_EN
                ST_CHECK: begin
                    if (ld_valid) begin
                        if (ld_data == csum) begin
                            state    <= ST_READY;
                            ld_done  <= 1'b1;
                            store_ok <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    ctrl_store_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (idx),
        .wr_data (ld_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_ctrl_store_loader.sv
// Self-checking bench for ctrl_store_loader: a word-counting reference model
// checked every cycle, plus directed literal checks.
module tb_ctrl_store_loader;
    import ctrl_pkg::*;

    localparam int DEPTH = 43;
`ifdef CTRL_STORE_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_start, ld_valid;
    logic [19:0] ld_data;
    logic        ld_ready, ld_done, ld_err, store_ok;
    logic [5:0]  rd_addr;
    logic [19:0] rd_data;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    logic [19:0] img [DEPTH];

    // Reference model state: a load is "busy" until DEPTH words (+ checksum) arrive
    bit          m_busy = 0, m_ok = 0, m_err = 0, m_done = 0;
    int          m_got = 0;
    logic [19:0] m_sum = '0;
    logic [19:0] m_mem [DEPTH];
    logic [19:0] m_rd = '0;

    ctrl_store_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld_start (ld_start),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_ready (ld_ready),
        .ld_done  (ld_done),
        .ld_err   (ld_err),
        .store_ok (store_ok),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_ok = 0; m_err = 0; m_done = 0; m_got = 0; m_sum = '0; m_rd = '0;
        end else begin
            m_rd   = (m_ok && int'(rd_addr) < DEPTH) ? m_mem[rd_addr] : 20'h0;
            m_done = 0;
            if (m_busy) begin
                if (ld_valid) begin
                    if (m_got < DEPTH) begin
                        m_mem[m_got] = ld_data;
                        m_sum        = m_sum ^ ld_data;
                        m_got++;
                        if (m_got == DEPTH && !CSUM) begin
                            m_busy = 0; m_ok = 1; m_done = 1;
                        end
                    end else begin
                        m_busy = 0;
                        if (ld_data == m_sum) begin
                            m_ok = 1; m_done = 1;
                        end else begin
                            m_err = 1;
                        end
                    end
                end
            end else if (ld_start) begin
                m_busy = 1; m_got = 0; m_sum = '0; m_ok = 0; m_err = 0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("cyc_ld_ready", 32'(ld_ready), 32'(m_busy));
        checkOutput("cyc_ld_done",  32'(ld_done),  32'(m_done));
        checkOutput("cyc_store_ok", 32'(store_ok), 32'(m_ok));
        checkOutput("cyc_ld_err",   32'(ld_err),   32'(m_err));
        checkOutput("cyc_rd_data",  32'(rd_data),  32'(m_rd));
        if (ld_done) done_cnt++;
    end

    task automatic applyStimulus(input logic start, input logic valid,
                                 input logic [19:0] data, input logic [5:0] addr);
        ld_start = start;
        ld_valid = valid;
        ld_data  = data;
        rd_addr  = addr;
        @(posedge clk);
        #1;
    endtask

    // One full load of img[]; gaps inserts idle cycles, bad corrupts the checksum
    task automatic loadImage(input bit gaps, input bit bad, input int probe_at);
        int          d0;
        logic [19:0] sum;
        d0  = done_cnt;
        sum = '0;
        applyStimulus(1'b1, 1'b0, 20'h0, rd_addr);
        for (int i = 0; i < DEPTH; i++) begin
            if (gaps && (i % 7 == 3))
                applyStimulus(1'b0, 1'b0, 20'hFFFFF, rd_addr);
            applyStimulus(i == 15, 1'b1, img[i], rd_addr);
            sum = sum ^ img[i];
            if (i == probe_at) begin
                checkOutput("probe_rd_data",  32'(rd_data),  32'h0);
                checkOutput("probe_store_ok", 32'(store_ok), 32'h0);
            end
        end
        if (CSUM)
            applyStimulus(1'b0, 1'b1, bad ? (sum ^ 20'h00001) : sum, rd_addr);
        applyStimulus(1'b0, 1'b0, 20'h0, rd_addr);
        applyStimulus(1'b0, 1'b0, 20'h0, rd_addr);
        checkOutput("done_pulses", 32'(done_cnt - d0), bad ? 32'd0 : 32'd1);
    endtask

    initial begin
        ld_start = 0; ld_valid = 0; ld_data = '0; rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_rd_data",  32'(rd_data),  32'h0);
        checkOutput("reset_store_ok", 32'(store_ok), 32'h0);
        checkOutput("reset_ld_ready", 32'(ld_ready), 32'h0);
        checkOutput("reset_ld_done",  32'(ld_done),  32'h0);
        checkOutput("reset_ld_err",   32'(ld_err),   32'h0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 20'h0, 6'd10);
        checkOutput("idle_rd_nop", 32'(rd_data), 32'h0);

        // Basic load of i -> i, probing address 5 mid-load
        for (int i = 0; i < DEPTH; i++) img[i] = 20'(i);
        rd_addr = 6'd5;
        loadImage(1'b0, 1'b0, 10);
        checkOutput("store_ok_after_load", 32'(store_ok), 32'h1);
        applyStimulus(1'b0, 1'b0, 20'h0, 6'd10);
        checkOutput("basic_rd10", 32'(rd_data), 32'h0000A);
        applyStimulus(1'b0, 1'b0, 20'h0, 6'd5);
        checkOutput("basic_rd5", 32'(rd_data), 32'h00005);
        applyStimulus(1'b0, 1'b0, 20'h0, 6'd42);
        checkOutput("basic_rd42", 32'(rd_data), 32'h0002A);

        // Real control word with valid gaps
        img[10] = 20'h0A001;
        loadImage(1'b1, 1'b0, -1);
        applyStimulus(1'b0, 1'b0, 20'h0, 6'd10);
        checkOutput("addi_rd10", 32'(rd_data), 32'h0A001);
        applyStimulus(1'b0, 1'b0, 20'h0, 6'd43);
        checkOutput("oob_rd43", 32'(rd_data), 32'h0);
        applyStimulus(1'b0, 1'b0, 20'h0, 6'd63);
        checkOutput("oob_rd63", 32'(rd_data), 32'h0);
        applyStimulus(1'b0, 1'b0, 20'h0, 6'd11);
        checkOutput("gap_rd11", 32'(rd_data), 32'h0000B);

        // Reset after 20 accepted words, then a fresh load
        applyStimulus(1'b1, 1'b0, 20'h0, 6'd5);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 20'(i + 100), 6'd5);
        rst_n = 1'b0;
        #2;
        checkOutput("midrst_ld_ready", 32'(ld_ready), 32'h0);
        checkOutput("midrst_store_ok", 32'(store_ok), 32'h0);
        checkOutput("midrst_rd_data",  32'(rd_data),  32'h0);
        checkOutput("midrst_ld_done",  32'(ld_done),  32'h0);
        applyStimulus(1'b0, 1'b0, 20'h0, 6'd5);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 20'h0, 6'd5);
        for (int i = 0; i < DEPTH; i++) img[i] = 20'(i);
        loadImage(1'b0, 1'b0, -1);
        applyStimulus(1'b0, 1'b0, 20'h0, 6'd20);
        checkOutput("reload_rd20", 32'(rd_data), 32'h00014);

        if (CSUM) begin
            loadImage(1'b0, 1'b1, -1);
            checkOutput("badsum_ld_err",   32'(ld_err),   32'h1);
            checkOutput("badsum_store_ok", 32'(store_ok), 32'h0);
            applyStimulus(1'b1, 1'b0, 20'h0, 6'd5);
            checkOutput("restart_clears_err", 32'(ld_err), 32'h0);
        end

        applyStimulus(1'b0, 1'b0, 20'h0, 6'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/ctrl_store_loader.md
CTRL_STORE_LOADER -- requirements
Module: ctrl_store_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, control-store address width.
REQ-002 SHALL have parameter DATA_W, default 20, control-word width.
REQ-003 SHALL have parameter DEPTH, default 43, number of control-store entries (0..42).
REQ-004 SHALL have one clock and an asynchronous, active-low reset:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have these ports:
- ld_start  input  1  pulse; begins a load.
- ld_valid  input  1  ld_data is valid.
- ld_data  input  DATA_W  control word to store.
- ld_ready  output  1  loader accepts a word this cycle.
- ld_done  output  1  one-cycle pulse when a load completes.
- ld_err  output  1  sticky error flag, cleared by ld_start.
- store_ok  output  1  store holds a complete, accepted image.
- rd_addr  input  ADDR_W  decoder-side lookup address.
- rd_data  output  DATA_W  registered control word.

Function
REQ-006 SHALL implement a writable control store of DEPTH x DATA_W, written only by the load FSM.
REQ-007 SHALL implement FSM states IDLE, LOAD, CHECK and READY.
- IDLE -> LOAD on ld_start.
- LOAD -> CHECK after the last word when CTRL_STORE_CHECKSUM_EN is defined; otherwise LOAD -> READY.
- CHECK -> READY on a checksum match, or -> IDLE on a mismatch.
- READY -> LOAD on ld_start.
REQ-008 SHALL drive ld_ready=1 only in LOAD and CHECK.
REQ-009 SHALL accept a word on ld_valid && ld_ready and, in LOAD, write it at word index idx, then increment idx.
REQ-010 SHALL reset idx to 0 on entry to LOAD; the word at idx==DEPTH-1 is the last word.
REQ-011 SHALL pulse ld_done for exactly one cycle on entry to READY, and SHALL set store_ok=1 in the same cycle.
REQ-012 SHALL clear store_ok on the cycle ld_start is accepted, and SHALL hold it at 0 until the next ld_done.
REQ-013 SHALL ignore ld_start while in LOAD or CHECK; no restart.
REQ-014 SHALL register rd_data with 1-cycle latency: rd_data(t+1) = store[rd_addr(t)] when store_ok(t)=1 and rd_addr(t)<DEPTH; otherwise rd_data(t+1) = 0 (NOP word).
REQ-015 SHALL allow a read and a write in the same cycle; reads are gated by store_ok, so there is no read-during-write hazard.
REQ-016 SHALL not stall on ld_valid gaps; idx advances only on accepted words.

Reset
REQ-017 SHALL, on rst_n=0, asynchronously force state=IDLE, idx=0, ld_ready=0, ld_done=0, ld_err=0, store_ok=0 and rd_data=0.
REQ-018 SHALL discard a load interrupted by reset; store contents are not cleared and become don't-care, with store_ok=0.

Configuration
REQ-019 SHALL support macro CTRL_STORE_CHECKSUM_EN.
- Defined: the loader keeps a running XOR of all DEPTH words. In CHECK it accepts one extra word. If that word equals the XOR, the FSM goes to READY. On a mismatch it sets ld_err=1, keeps store_ok=0 and returns to IDLE with no ld_done.
- Undefined: there is no CHECK state and no XOR logic, and ld_err stays 0.

Structure
REQ-020 SHALL take ADDR_W/DATA_W defaults, DEPTH and the FSM state enum from shared package ctrl_pkg.
REQ-021 SHALL place the control-word field offsets in ctrl_pkg: branch[19], immsel[18:16], regwrite[15], unsigned[14], alusrc[13], asel[12], aluop[11:8], memwrite[7], st_size[6:5], ld_type[4:2], wbsel[1:0].
REQ-022 SHALL use one sub-module, ctrl_store_ram: a synchronous-write, registered-read DEPTH x DATA_W array.

Verification
REQ-023 SHALL cover a basic load and read: load words i=0..42 with value i, plus a checksum if enabled -> ld_done pulses once; rd_addr=10 gives rd_data=0x0000A one cycle later.
REQ-024 SHALL cover a real control word: word 10 = 0x0A001 (I-type ADDI); read addr 10 -> rd_data=0x0A001; read addr 43 -> 0x00000.
REQ-025 SHALL cover reads during a load: issue rd_addr=5 while in LOAD -> rd_data=0 and store_ok=0; after ld_done -> stored word 5.
REQ-026 SHALL cover ld_valid gaps: toggle ld_valid 1-0-1 during the load -> exactly 43 writes, with ld_done after the 43rd accepted word.
REQ-027 SHALL cover reset mid-load: assert rst_n=0 at idx=20 -> all outputs 0 and state IDLE; a fresh full load then succeeds.
REQ-028 SHALL cover a bad checksum with CTRL_STORE_CHECKSUM_EN defined: send checksum XOR^0x00001 -> ld_err=1, store_ok=0, no ld_done; the next ld_start clears ld_err.
